// File: rtl/cpu_defs.sv
// Shared CPU definitions: opcode constants, instruction field positions and field helpers.
package cpu_defs;

  localparam int unsigned RegAddrW = 5;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpBne   = 6'h05;
  localparam logic [5:0] OpAndi  = 6'h0C;
  localparam logic [5:0] OpOri   = 6'h0D;
  localparam logic [5:0] OpXori  = 6'h0E;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;

  localparam int unsigned OpMsb    = 31;
  localparam int unsigned OpLsb    = 26;
  localparam int unsigned RsMsb    = 25;
  localparam int unsigned RsLsb    = 21;
  localparam int unsigned RtMsb    = 20;
  localparam int unsigned RtLsb    = 16;
  localparam int unsigned RdMsb    = 15;
  localparam int unsigned RdLsb    = 11;
  localparam int unsigned FunctMsb = 5;
  localparam int unsigned ImmMsb   = 15;

  typedef struct packed {
    logic [5:0]          op;
    logic [RegAddrW-1:0] rs;
    logic [RegAddrW-1:0] rt;
    logic [RegAddrW-1:0] rd;
    logic [5:0]          funct;
    logic [15:0]         imm16;
  } instr_fields_t;

  function automatic instr_fields_t split_fields(input logic [31:0] ir);
    instr_fields_t f;
    f.op    = ir[OpMsb:OpLsb];
    f.rs    = ir[RsMsb:RsLsb];
    f.rt    = ir[RtMsb:RtLsb];
    f.rd    = ir[RdMsb:RdLsb];
    f.funct = ir[FunctMsb:0];
    f.imm16 = ir[ImmMsb:0];
    return f;
  endfunction

  // Only these opcodes consume rt as an operand; others use it as a destination.
  function automatic logic rt_is_src(input logic [5:0] op);
    return (op == OpRtype) || (op == OpBeq) || (op == OpBne) || (op == OpSw);
  endfunction

  function automatic logic imm_zero_ext(input logic [5:0] op);
    return (op == OpAndi) || (op == OpOri) || (op == OpXori);
  endfunction

endpackage

// File: rtl/regfile.sv
// Register file: two asynchronous read ports with write bypass, one synchronous write port.
module regfile import cpu_defs::*; #(
  parameter int unsigned DataW = 32,
  parameter int unsigned NRegs = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [RegAddrW-1:0] raddr_a_i,
  input  logic [RegAddrW-1:0] raddr_b_i,
  output logic [DataW-1:0]    rdata_a_o,
  output logic [DataW-1:0]    rdata_b_o,
  input  logic                we_i,
  input  logic [RegAddrW-1:0] waddr_i,
  input  logic [DataW-1:0]    wdata_i
);

  logic [DataW-1:0] regs_q [NRegs];
  logic             wr_en;

  assign wr_en = we_i && (waddr_i != '0) && (32'(waddr_i) < NRegs);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < int'(NRegs); i++) regs_q[i] <= '0;
    end else if (wr_en) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  // Same-cycle writeback is forwarded so decode never sees a stale value.
  function automatic logic [DataW-1:0] rd_port(input logic [RegAddrW-1:0] addr);
    if (addr == '0)                    return '0;
    else if (wr_en && addr == waddr_i) return wdata_i;
    else if (32'(addr) < NRegs)        return regs_q[addr];
    else                               return '0;
  endfunction

  always_comb begin
    rdata_a_o = rd_port(raddr_a_i);
    rdata_b_o = rd_port(raddr_b_i);
  end

endmodule

// File: rtl/decode.sv
// Instruction decode stage: field split, register read, load-use hazard stall and ID/EX register.
module decode import cpu_defs::*; #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned NREGS  = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [31:0]         ir_i,
  input  logic [31:0]         npc_i,
  input  logic                valid_i,
  input  logic                flush_i,
  input  logic                wb_we_i,
  input  logic [RegAddrW-1:0] wb_addr_i,
  input  logic [DATA_W-1:0]   wb_data_i,
  input  logic                ex_memread_i,
  input  logic [RegAddrW-1:0] ex_rd_i,
  output logic                stall_o,
  output logic [DATA_W-1:0]   a_o,
  output logic [DATA_W-1:0]   b_o,
  output logic [DATA_W-1:0]   imm_o,
  output logic [31:0]         npc_o,
  output logic [RegAddrW-1:0] rs_o,
  output logic [RegAddrW-1:0] rt_o,
  output logic [RegAddrW-1:0] dest_o,
  output logic [5:0]          op_o,
  output logic [5:0]          funct_o,
  output logic                valid_o
);

  instr_fields_t       f;
  logic [DATA_W-1:0]   rs_data, rt_data, imm_ext;
  logic [RegAddrW-1:0] dest;
  logic                hazard, load;

  assign f = split_fields(ir_i);

  regfile #(
    .DataW(DATA_W),
    .NRegs(NREGS)
  ) u_regfile (
    .clk      (clk),
    .rst      (rst),
    .raddr_a_i(f.rs),
    .raddr_b_i(f.rt),
    .rdata_a_o(rs_data),
    .rdata_b_o(rt_data),
    .we_i     (wb_we_i),
    .waddr_i  (wb_addr_i),
    .wdata_i  (wb_data_i)
  );

  always_comb begin
    imm_ext = imm_zero_ext(f.op) ? {{(DATA_W-16){1'b0}}, f.imm16}
                                 : {{(DATA_W-16){f.imm16[15]}}, f.imm16};
    dest    = (f.op == OpRtype) ? f.rd : f.rt;
    hazard  = valid_i && ex_memread_i && (ex_rd_i != '0) &&
              ((ex_rd_i == f.rs) || (rt_is_src(f.op) && (ex_rd_i == f.rt)));
    stall_o = hazard && !rst;
    load    = valid_i && !flush_i && !stall_o;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst || !load) begin
      a_o     <= '0;
      b_o     <= '0;
      imm_o   <= '0;
      npc_o   <= '0;
      rs_o    <= '0;
      rt_o    <= '0;
      dest_o  <= '0;
      op_o    <= '0;
      funct_o <= '0;
      valid_o <= 1'b0;
    end else begin
      a_o     <= rs_data;
      b_o     <= rt_data;
      imm_o   <= imm_ext;
      npc_o   <= npc_i;
      rs_o    <= f.rs;
      rt_o    <= f.rt;
      dest_o  <= dest;
      op_o    <= f.op;
      funct_o <= f.funct;
      valid_o <= 1'b1;
    end
  end

endmodule

// File: tb/tb_decode.sv
// Bench for decode: directed vector table, reset sequences, random stimulus against a reference model.
module tb_decode;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] ir = '0, npc = '0, wb_data = '0;
  logic        valid = 1'b0, flush = 1'b0, wb_we = 1'b0, ex_mr = 1'b0;
  logic [4:0]  wb_addr = '0, ex_rd = '0;
  logic        stall_o, valid_o;
  logic [31:0] a_o, b_o, imm_o, npc_o;
  logic [4:0]  rs_o, rt_o, dest_o;
  logic [5:0]  op_o, funct_o;

  always #5 clk = ~clk;

  decode #(.DATA_W(32), .NREGS(32)) dut (
    .clk(clk), .rst(rst), .ir_i(ir), .npc_i(npc), .valid_i(valid), .flush_i(flush),
    .wb_we_i(wb_we), .wb_addr_i(wb_addr), .wb_data_i(wb_data),
    .ex_memread_i(ex_mr), .ex_rd_i(ex_rd), .stall_o(stall_o),
    .a_o(a_o), .b_o(b_o), .imm_o(imm_o), .npc_o(npc_o), .rs_o(rs_o), .rt_o(rt_o),
    .dest_o(dest_o), .op_o(op_o), .funct_o(funct_o), .valid_o(valid_o)
  );

  typedef struct {
    logic [31:0] ir, npc;
    logic        valid, flush, wb_we;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic        ex_mr;
    logic [4:0]  ex_rd;
    logic        e_stall, e_valid;
    logic [31:0] e_a, e_b, e_imm;
    logic [4:0]  e_dest;
  } vec_t;

  typedef struct {
    logic        stall, valid;
    logic [31:0] a, b, imm, npc;
    logic [4:0]  rs, rt, dest;
    logic [5:0]  op, funct;
  } exp_t;

  int unsigned n_vec = 0, n_err = 0;
  logic [31:0] mregs [32];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    n_vec++;
    if (act !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%08h, want 0x%08h", nm, act, want);
    end
  endtask

  function automatic logic [31:0] mread(input int unsigned r, input vec_t v);
    if (r == 0) return 32'h0;
    if (v.wb_we && r == int'(v.wb_addr)) return v.wb_data;
    return mregs[r];
  endfunction

  // Reference decode computed arithmetically from the instruction word.
  function automatic exp_t model(input vec_t v);
    exp_t e;
    int unsigned op, rs, rt, rd;
    bit rt_src, zext;
    op = v.ir >> 26;
    rs = (v.ir >> 21) % 32;
    rt = (v.ir >> 16) % 32;
    rd = (v.ir >> 11) % 32;
    rt_src = (op == 0) || (op == 4) || (op == 5) || (op == 43);
    zext = (op >= 12) && (op <= 14);
    e.stall = v.valid && v.ex_mr && v.ex_rd != 0 &&
              (int'(v.ex_rd) == rs || (rt_src && int'(v.ex_rd) == rt));
    e.valid = v.valid && !v.flush && !e.stall;
    e = '{stall: e.stall, valid: e.valid, default: '0};
    if (e.valid) begin
      e.a = mread(rs, v);
      e.b = mread(rt, v);
      e.imm = v.ir % 65536;
      if (!zext && e.imm >= 32768) e.imm = e.imm + 32'hFFFF0000;
      e.npc = v.npc;
      e.rs = 5'(rs);
      e.rt = 5'(rt);
      e.dest = 5'((op == 0) ? rd : rt);
      e.op = 6'(op);
      e.funct = 6'(v.ir % 64);
    end
    return e;
  endfunction

  task automatic drive(input vec_t v);
    ir = v.ir; npc = v.npc; valid = v.valid; flush = v.flush;
    wb_we = v.wb_we; wb_addr = v.wb_addr; wb_data = v.wb_data;
    ex_mr = v.ex_mr; ex_rd = v.ex_rd;
  endtask

  // One cycle: drive at posedge+1, check stall before the edge, check ID/EX at posedge+1.
  task automatic apply(input vec_t v, input bit tab, input string tag);
    exp_t e;
    drive(v);
    #1;
    e = model(v);
    chk({tag, " stall"}, 32'(stall_o), 32'(e.stall));
    if (tab) chk({tag, " stall(tab)"}, 32'(stall_o), 32'(v.e_stall));
    @(posedge clk);
    if (v.wb_we && v.wb_addr != 0) mregs[v.wb_addr] = v.wb_data;
    #1;
    chk({tag, " valid"}, 32'(valid_o), 32'(e.valid));
    chk({tag, " a"}, a_o, e.a);
    chk({tag, " b"}, b_o, e.b);
    chk({tag, " imm"}, imm_o, e.imm);
    chk({tag, " npc"}, npc_o, e.npc);
    chk({tag, " rs"}, 32'(rs_o), 32'(e.rs));
    chk({tag, " rt"}, 32'(rt_o), 32'(e.rt));
    chk({tag, " dest"}, 32'(dest_o), 32'(e.dest));
    chk({tag, " op"}, 32'(op_o), 32'(e.op));
    chk({tag, " funct"}, 32'(funct_o), 32'(e.funct));
    if (tab) begin
      chk({tag, " valid(tab)"}, 32'(valid_o), 32'(v.e_valid));
      chk({tag, " a(tab)"}, a_o, v.e_a);
      chk({tag, " b(tab)"}, b_o, v.e_b);
      chk({tag, " imm(tab)"}, imm_o, v.e_imm);
      chk({tag, " dest(tab)"}, 32'(dest_o), 32'(v.e_dest));
    end
  endtask

  function automatic vec_t rand_vec(input int unsigned i);
    vec_t v;
    int unsigned ops [10] = '{0, 4, 5, 12, 13, 14, 35, 43, 8, 0};
    int unsigned op;
    op = ops[$urandom_range(9)];
    if ($urandom_range(9) == 0) op = $urandom_range(63);
    v = '{default: '0};
    v.ir = (op << 26) | ($urandom_range(7) << 21) | ($urandom_range(7) << 16) |
           ($urandom_range(7) << 11) | ($urandom % 2048);
    if ($urandom_range(1) == 1) v.ir[15] = 1'b1;
    v.npc = 32'h1000 + 4 * i;
    v.valid = $urandom_range(9) < 8;
    v.flush = $urandom_range(9) == 0;
    v.wb_we = $urandom_range(1) == 1;
    v.wb_addr = 5'($urandom_range(7));
    v.wb_data = $urandom;
    v.ex_mr = $urandom_range(9) < 3;
    v.ex_rd = 5'($urandom_range(7));
    return v;
  endfunction

  vec_t tab[$];
  vec_t hv;

  initial begin
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    //        ir            npc           vl    fl    we    wa     wdata         mr    exrd
    //        stall vld   a             b             imm           dest
    tab.push_back('{32'h00000000, 32'h100, 1'b0, 1'b0, 1'b1, 5'd5, 32'h00001234, 1'b0, 5'd0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    tab.push_back('{32'h00A53020, 32'h104, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h1234, 32'h1234, 32'h3020, 5'd6});
    tab.push_back('{32'h3042FFFF, 32'h108, 1'b1, 1'b0, 1'b1, 5'd2, 32'h00000F0F, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h0F0F, 32'h0F0F, 32'h0000FFFF, 5'd2});
    tab.push_back('{32'h2042FFFF, 32'h10C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h0F0F, 32'h0F0F, 32'hFFFFFFFF, 5'd2});
    tab.push_back('{32'h00A53020, 32'h110, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
                    1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    tab.push_back('{32'h00A53020, 32'h114, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd0,
                    1'b0, 1'b1, 32'h1234, 32'h1234, 32'h3020, 5'd6});
    tab.push_back('{32'h20E80001, 32'h118, 1'b1, 1'b0, 1'b1, 5'd7, 32'h0000DEAD, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'hDEAD, 32'h0, 32'h1, 5'd8});
    tab.push_back('{32'h20090005, 32'h11C, 1'b1, 1'b0, 1'b1, 5'd0, 32'h0000BEEF, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h0, 32'h0, 32'h5, 5'd9});
    tab.push_back('{32'h00A53020, 32'h120, 1'b1, 1'b1, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
                    1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    tab.push_back('{32'h00A53020, 32'h124, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h1234, 32'h1234, 32'h3020, 5'd6});
    tab.push_back('{32'h10270010, 32'h128, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                    1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    tab.push_back('{32'h8C270000, 32'h12C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                    1'b0, 1'b1, 32'h0, 32'hDEAD, 32'h0, 5'd7});
    tab.push_back('{32'hAC250000, 32'h130, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd5,
                    1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    tab.push_back('{32'h14270000, 32'h134, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 5'd7,
                    1'b1, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});
    tab.push_back('{32'h34038000, 32'h138, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h0, 32'h0, 32'h00008000, 5'd3});
    tab.push_back('{32'h3804FFFF, 32'h13C, 1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 1'b1, 32'h0, 32'h0, 32'h0000FFFF, 5'd4});
    tab.push_back('{32'h00A53020, 32'h140, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 1'b0, 5'd0,
                    1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 5'd0});

    // Reset held: outputs clear and stall suppressed despite a hazard on the inputs.
    ir = 32'h00A53020; valid = 1'b1; ex_mr = 1'b1; ex_rd = 5'd5;
    repeat (2) @(posedge clk);
    #1;
    chk("reset valid", 32'(valid_o), 32'h0);
    chk("reset a", a_o, 32'h0);
    chk("reset dest", 32'(dest_o), 32'h0);
    chk("reset stall", 32'(stall_o), 32'h0);
    rst = 1'b0;
    ex_mr = 1'b0; valid = 1'b0;
    @(posedge clk);
    #1;

    foreach (tab[i]) apply(tab[i], 1'b1, $sformatf("tab%0d", i));

    for (int i = 0; i < 300; i++) apply(rand_vec(i), 1'b0, $sformatf("rnd%0d", i));

    // Mid-stream reset: writeback of that cycle is lost and outputs clear at once.
    hv = '{default: '0};
    hv.ir = 32'h00A53020; hv.npc = 32'h200; hv.valid = 1'b1;
    hv.wb_we = 1'b1; hv.wb_addr = 5'd5; hv.wb_data = 32'h1234;
    apply(hv, 1'b0, "pre-rst");
    chk("pre-rst valid", 32'(valid_o), 32'h1);
    hv.wb_data = 32'h5555; hv.ex_mr = 1'b1; hv.ex_rd = 5'd5;
    drive(hv);
    #2;
    rst = 1'b1;
    #1;
    chk("mid-rst valid", 32'(valid_o), 32'h0);
    chk("mid-rst a", a_o, 32'h0);
    chk("mid-rst npc", npc_o, 32'h0);
    chk("mid-rst stall", 32'(stall_o), 32'h0);
    for (int i = 0; i < 32; i++) mregs[i] = '0;
    @(posedge clk);
    #3;
    rst = 1'b0;
    hv.wb_we = 1'b0; hv.ex_mr = 1'b0;
    drive(hv);
    @(posedge clk);
    #1;
    chk("post-rst valid", 32'(valid_o), 32'h1);
    chk("post-rst r5", a_o, 32'h0);
    chk("post-rst dest", 32'(dest_o), 32'h6);

    for (int i = 0; i < 100; i++) apply(rand_vec(i), 1'b0, $sformatf("rnd2_%0d", i));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
